// File: rtl/recovery_ctrl_if.sv
// Bundle between the retire stage and the mispredict recovery controller.
// master: retire-side driver (inputs of the controller); slave: the controller.
interface recovery_ctrl_if #(
    parameter int N_WAY             = 2,
    parameter int CDB_BITS          = 6,
    parameter int XLEN              = 32,
    parameter int RESTORE_PER_CYCLE = 4
) ();
    logic                                  branch_haz;
    logic [XLEN-1:0]                       retire_branch_PC;
    logic [N_WAY-1:0]                      retire_halt;
    logic [32*CDB_BITS-1:0]                arch_reg_next;

    logic                                  stall_dispatch;
    logic                                  flush;
    logic                                  restore_valid;
    logic [4:0]                            restore_idx;
    logic [RESTORE_PER_CYCLE*CDB_BITS-1:0] restore_tag;
    logic                                  redirect_valid;
    logic [XLEN-1:0]                       redirect_pc;
    logic                                  halted;

    modport master (
        output branch_haz, retire_branch_PC, retire_halt, arch_reg_next,
        input  stall_dispatch, flush, restore_valid, restore_idx, restore_tag,
               redirect_valid, redirect_pc, halted
    );

    modport slave (
        input  branch_haz, retire_branch_PC, retire_halt, arch_reg_next,
        output stall_dispatch, flush, restore_valid, restore_idx, restore_tag,
               redirect_valid, redirect_pc, halted
    );
endinterface

// File: rtl/recovery_ctrl.sv
// Mispredict recovery sequencer: on a retiring mispredicted branch it flushes
// the pipeline, replays the architectural map into the rename map a group at
// a time, then redirects fetch. A retired halt parks the core until reset.
module recovery_ctrl #(
    parameter int N_WAY             = 2,
    parameter int CDB_BITS          = 6,
    parameter int XLEN              = 32,
    parameter int RESTORE_PER_CYCLE = 4
) (
    input logic            clock,
    input logic            reset,
    recovery_ctrl_if.slave bus
);
    localparam int GROUPS     = 32 / RESTORE_PER_CYCLE;
    localparam int CNT_W      = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int GROUP_BITS = RESTORE_PER_CYCLE * CDB_BITS;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        RESTORE  = 3'd2,
        REDIRECT = 3'd3,
        HALTED   = 3'd4
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [XLEN-1:0]        pc_reg;
    logic [32*CDB_BITS-1:0] snapshot_reg;
    logic                   capture;

    // Snapshot viewed as one tag slice per restore group.
    logic [GROUP_BITS-1:0]  group_tags [GROUPS];

    genvar gi;
    generate
        for (gi = 0; gi < GROUPS; gi++) begin : g_group
            assign group_tags[gi] = snapshot_reg[gi*GROUP_BITS +: GROUP_BITS];
        end
    endgenerate

    // State and group counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Target PC and architectural map are captured only when recovery starts,
    // so later changes on the retire bus cannot corrupt an ongoing restore.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_reg       <= '0;
            snapshot_reg <= '0;
        end else if (capture) begin
            pc_reg       <= bus.retire_branch_PC;
            snapshot_reg <= bus.arch_reg_next;
        end
    end

    // Next-state logic; halt wins over a same-cycle mispredict, and the retire
    // inputs are only looked at while idle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|bus.retire_halt) begin
                    state_next = HALTED;
                end else if (bus.branch_haz) begin
                    state_next = FLUSH;
                    capture    = 1'b1;
                end
            end
            FLUSH: begin
                cnt_next   = '0;
                state_next = RESTORE;
            end
            RESTORE: begin
                // Hold on the last group instead of wrapping back to group 0.
                if (cnt_reg == CNT_W'(GROUPS - 1)) begin
                    state_next = REDIRECT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            REDIRECT: begin
                state_next = IDLE;
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; data buses are zero when not valid.
    always_comb begin
        bus.stall_dispatch = 1'b0;
        bus.flush          = 1'b0;
        bus.restore_valid  = 1'b0;
        bus.restore_idx    = 5'd0;
        bus.restore_tag    = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halted         = 1'b0;
        case (state_reg)
            FLUSH: begin
                bus.flush          = 1'b1;
                bus.stall_dispatch = 1'b1;
            end
            RESTORE: begin
                bus.restore_valid  = 1'b1;
                bus.stall_dispatch = 1'b1;
                bus.restore_idx    = 5'(5'(cnt_reg) * 5'(RESTORE_PER_CYCLE));
                bus.restore_tag    = group_tags[cnt_reg];
            end
            REDIRECT: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = pc_reg;
                bus.stall_dispatch = 1'b1;
            end
            HALTED: begin
                bus.halted         = 1'b1;
                bus.stall_dispatch = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_recovery_ctrl.sv
// Bench for recovery_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a cycle-offset reference model.
module tb_recovery_ctrl;
    localparam int N_WAY = 2;
    localparam int CDB   = 6;
    localparam int XLEN  = 32;
    localparam int RPC   = 4;
    localparam int TAGW  = RPC * CDB;

    logic clock;
    logic reset;

    recovery_ctrl_if #(.N_WAY(N_WAY), .CDB_BITS(CDB), .XLEN(XLEN), .RESTORE_PER_CYCLE(RPC)) bus ();

    recovery_ctrl #(.N_WAY(N_WAY), .CDB_BITS(CDB), .XLEN(XLEN), .RESTORE_PER_CYCLE(RPC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 recovering, 2 halted. While recovering,
    // phase counts cycles since the triggering edge: 1 flush, 2..9 restore,
    // 10 redirect.
    int              m_mode  = 0;
    int              m_phase = 0;
    logic [XLEN-1:0] m_pc    = '0;
    logic [CDB-1:0]  m_snap  [32];
    logic [CDB-1:0]  arch_vals [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_arch();
        for (int i = 0; i < 32; i++) bus.arch_reg_next[i*CDB +: CDB] = arch_vals[i];
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_phase = 0;
        m_pc    = '0;
        for (int i = 0; i < 32; i++) m_snap[i] = '0;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (bus.retire_halt != '0) begin
                m_mode = 2;
            end else if (bus.branch_haz) begin
                m_mode  = 1;
                m_phase = 1;
                m_pc    = bus.retire_branch_PC;
                for (int i = 0; i < 32; i++) m_snap[i] = arch_vals[i];
            end
        end else if (m_mode == 1) begin
            if (m_phase == 10) begin
                m_mode  = 0;
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end
    endtask

    task automatic check_all();
        logic            e_rv;
        int              e_idx;
        logic [TAGW-1:0] e_tag;
        e_rv  = (m_mode == 1) && (m_phase >= 2) && (m_phase <= 9);
        e_idx = e_rv ? (m_phase - 2) * RPC : 0;
        e_tag = '0;
        if (e_rv) for (int j = 0; j < RPC; j++) e_tag[j*CDB +: CDB] = m_snap[e_idx + j];
        chk("stall_dispatch", 64'(bus.stall_dispatch), 64'(m_mode != 0));
        chk("flush", 64'(bus.flush), 64'((m_mode == 1) && (m_phase == 1)));
        chk("restore_valid", 64'(bus.restore_valid), 64'(e_rv));
        chk("restore_idx", 64'(bus.restore_idx), 64'(e_idx));
        chk("restore_tag", 64'(bus.restore_tag), 64'(e_tag));
        chk("redirect_valid", 64'(bus.redirect_valid), 64'((m_mode == 1) && (m_phase == 10)));
        chk("redirect_pc", 64'(bus.redirect_pc), ((m_mode == 1) && (m_phase == 10)) ? 64'(m_pc) : 64'd0);
        chk("halted", 64'(bus.halted), 64'(m_mode == 2));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int stall_cnt;
        int seen_flush;

        reset = 1'b0;
        bus.branch_haz = 1'b0;
        bus.retire_branch_PC = '0;
        bus.retire_halt = '0;
        for (int i = 0; i < 32; i++) arch_vals[i] = '0;
        drive_arch();
        model_reset();

        // Reset state.
        #2;
        check_all();
        step();
        step();
        #2 reset = 1'b1;
        step();

        // Directed mispredict; map changed to zeros mid-restore must not leak.
        for (int i = 0; i < 32; i++) arch_vals[i] = CDB'(i + 32);
        drive_arch();
        bus.branch_haz = 1'b1;
        bus.retire_branch_PC = 32'h0000_1040;
        stall_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            stall_cnt += int'(bus.stall_dispatch);
            bus.branch_haz = 1'b0;
            if (c == 2) begin
                for (int i = 0; i < 32; i++) arch_vals[i] = '0;
                drive_arch();
            end
        end
        chk("stall_len", 64'(stall_cnt), 64'd10);

        // branch_haz held for 5 cycles with changing PCs: one sequence only.
        for (int i = 0; i < 32; i++) arch_vals[i] = CDB'($urandom);
        drive_arch();
        seen_flush = 0;
        for (int c = 0; c < 14; c++) begin
            bus.branch_haz = (c < 5);
            bus.retire_branch_PC = $urandom;
            step();
            seen_flush += int'(bus.flush);
        end
        chk("retrigger_flush_count", 64'(seen_flush), 64'd1);

        // Back-to-back: new trigger in the idle cycle right after redirect.
        bus.branch_haz = 1'b1;
        bus.retire_branch_PC = $urandom;
        step();
        bus.branch_haz = 1'b0;
        while (m_phase != 10) step();
        for (int i = 0; i < 32; i++) arch_vals[i] = CDB'($urandom);
        drive_arch();
        bus.branch_haz = 1'b1;
        bus.retire_branch_PC = $urandom;
        step();
        chk("b2b_idle_after_redirect", 64'(bus.stall_dispatch), 64'd0);
        step();
        chk("b2b_flush", 64'(bus.flush), 64'd1);
        bus.branch_haz = 1'b0;
        for (int c = 0; c < 10; c++) step();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            bus.branch_haz = ($urandom_range(0, 3) == 0);
            bus.retire_branch_PC = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 32; i++) arch_vals[i] = CDB'($urandom);
                drive_arch();
            end
            step();
        end
        bus.branch_haz = 1'b0;
        for (int c = 0; c < 12; c++) step();

        // Reset at the 4th restore cycle: outputs drop before the next edge.
        for (int i = 0; i < 32; i++) arch_vals[i] = CDB'($urandom);
        drive_arch();
        bus.branch_haz = 1'b1;
        bus.retire_branch_PC = $urandom;
        step();
        bus.branch_haz = 1'b0;
        for (int c = 0; c < 4; c++) step();
        chk("fourth_restore_idx", 64'(bus.restore_idx), 64'd12);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        step();
        #2 reset = 1'b1;
        for (int i = 0; i < 32; i++) arch_vals[i] = CDB'($urandom);
        drive_arch();
        bus.branch_haz = 1'b1;
        bus.retire_branch_PC = $urandom;
        step();
        bus.branch_haz = 1'b0;
        for (int c = 0; c < 11; c++) step();

        // Halt together with mispredict: halted wins, never flushes.
        bus.retire_halt = 2'b10;
        bus.branch_haz = 1'b1;
        bus.retire_branch_PC = $urandom;
        seen_flush = 0;
        step();
        bus.retire_halt = '0;
        for (int c = 0; c < 20; c++) begin
            bus.branch_haz = $urandom_range(0, 1);
            bus.retire_halt = N_WAY'($urandom);
            step();
            seen_flush += int'(bus.flush);
        end
        chk("halt_no_flush", 64'(seen_flush), 64'd0);

        // Reset out of HALTED; first edge after release must act on branch_haz.
        #2 reset = 1'b0;
        model_reset();
        bus.retire_halt = '0;
        bus.branch_haz = 1'b1;
        bus.retire_branch_PC = $urandom;
        #1;
        check_all();
        @(negedge clock);
        reset = 1'b1;
        step();
        bus.branch_haz = 1'b0;
        for (int c = 0; c < 11; c++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
